// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// master drives start and operands; slave returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per cycle, LSB first.
// The result registers only move when an operation completes, so they hold across idle time.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit, bo_bit;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    bor_d        = bor_q;
    borrow_out_d = borrow_out_q;
    done_d       = 1'b0;

    // Full-subtractor on the current LSBs of the working operands.
    d_bit  = x_q[0] ^ y_q[0] ^ bor_q;
    bo_bit = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & bor_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.a;
          y_d     = bus.b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d               = x_q >> 1;
        y_d               = y_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = d_bit;
        bor_d             = bo_bit;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        diff_d       = res_q;
        borrow_out_d = bor_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      bor_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      bor_q        <= bor_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor at WIDTH 1, 8 and 16 against an arithmetic (a - b, a < b) model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(1))  if1 ();
  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  always #5 clk = ~clk;

  // sel: 0 -> WIDTH 1, 1 -> WIDTH 8, 2 -> WIDTH 16
  task automatic drive(input int sel, input logic st, input logic [31:0] av, input logic [31:0] bv);
    case (sel)
      0: begin if1.start = st;  if1.a = av[0:0];   if1.b = bv[0:0];   end
      1: begin if8.start = st;  if8.a = av[7:0];   if8.b = bv[7:0];   end
      2: begin if16.start = st; if16.a = av[15:0]; if16.b = bv[15:0]; end
      default: ;
    endcase
  endtask

  task automatic sample(input int sel, output logic bz, output logic dn,
                        output logic [31:0] df, output logic bo);
    bz = 1'b0; dn = 1'b0; bo = 1'b0; df = '0;
    case (sel)
      0: begin bz = if1.busy;  dn = if1.done;  df[0:0]  = if1.diff;  bo = if1.borrow_out;  end
      1: begin bz = if8.busy;  dn = if8.done;  df[7:0]  = if8.diff;  bo = if8.borrow_out;  end
      2: begin bz = if16.busy; dn = if16.done; df[15:0] = if16.diff; bo = if16.borrow_out; end
      default: ;
    endcase
  endtask

  // Issues one operation from an idle falling edge and returns what was observed.
  // cyc is the number of rising edges after the accept edge at which done was seen (0 = never).
  task automatic run_op(input int sel, input int width, input logic [31:0] av, input logic [31:0] bv,
                        output int cyc, output logic [31:0] dres, output logic bres,
                        output bit unstable, output bit busy_bad);
    logic bz, dn, bo;
    logic [31:0] df, prev;
    sample(sel, bz, dn, prev, bo);
    cyc = 0; dres = '0; bres = 1'b0; unstable = 1'b0; busy_bad = 1'b0;
    drive(sel, 1'b1, av, bv);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, $urandom, $urandom);
    for (int c = 1; c <= width + 6 && cyc == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      sample(sel, bz, dn, df, bo);
      if (dn) begin
        cyc = c; dres = df; bres = bo;
      end else begin
        if (df !== prev) unstable = 1'b1;
        if (!bz) busy_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic bz, dn, bo;
    logic [31:0] df;
    rst_n = 1'b1;
    drive(0, 1'b0, 0, 0); drive(1, 1'b0, 0, 0); drive(2, 1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sample(s, bz, dn, df, bo);
      checks++;
      if ({bz, dn, bo} !== 3'b000 || df !== 32'd0)
        $display("[TB] FAIL reset_state[%0d]: got busy=%b done=%b diff=%h borrow=%b, expected all zero",
                 s, bz, dn, df, bo);
      if ({bz, dn, bo} !== 3'b000 || df !== 32'd0) errors++;
    end
    // start must not be accepted while reset is held
    drive(1, 1'b1, 32'h5A, 32'h23);
    repeat (2) @(negedge clk);
    sample(1, bz, dn, df, bo);
    checks++;
    if (bz !== 1'b0) begin
      $display("[TB] FAIL reset_hold_busy: got %b expected 0", bz);
      errors++;
    end
    drive(1, 1'b0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'h5A, 8'h00, 8'hA5};
    logic [7:0] tb [3] = '{8'h23, 8'h01, 8'hA5};
    logic [7:0] ed [3] = '{8'h37, 8'hFF, 8'h00};
    logic       eb [3] = '{1'b0, 1'b1, 1'b0};
    logic bz, dn, bo, bres;
    logic [31:0] df, dres;
    int cyc;
    bit uns, bb;
    for (int i = 0; i < 3; i++) begin
      run_op(1, 8, {24'd0, ta[i]}, {24'd0, tb[i]}, cyc, dres, bres, uns, bb);
      checks++;
      if (cyc != 9) begin
        $display("[TB] FAIL directed_latency[%0d]: got %0d edges expected 9", i, cyc); errors++;
      end
      checks++;
      if (dres !== {24'd0, ed[i]}) begin
        $display("[TB] FAIL directed_diff[%0d]: got %h expected %h", i, dres, ed[i]); errors++;
      end
      checks++;
      if (bres !== eb[i]) begin
        $display("[TB] FAIL directed_borrow[%0d]: got %b expected %b", i, bres, eb[i]); errors++;
      end
      checks++;
      if (uns || bb) begin
        $display("[TB] FAIL directed_run[%0d]: unstable=%b busy_low=%b expected 0 0", i, uns, bb); errors++;
      end
      @(negedge clk);
      sample(1, bz, dn, df, bo);
      checks++;
      if (dn !== 1'b0 || df !== {24'd0, ed[i]} || bz !== 1'b0) begin
        $display("[TB] FAIL directed_after[%0d]: got done=%b busy=%b diff=%h expected 0 0 %h",
                 i, dn, bz, df, ed[i]);
        errors++;
      end
    end
  endtask

  // start held high with fresh operands every cycle: accepts land every 10 edges.
  task automatic test_back_to_back();
    logic [7:0] sa [64];
    logic [7:0] sb [64];
    logic [7:0] last_d, ed;
    logic bz, dn, bo, exp_done;
    logic [31:0] df;
    last_d = if8.diff;
    for (int n = 0; n <= 44; n++) begin
      if (n > 0) begin
        sample(1, bz, dn, df, bo);
        exp_done = (n >= 10) && (n % 10 == 0);
        checks++;
        if (dn !== exp_done) begin
          $display("[TB] FAIL b2b_done[%0d]: got %b expected %b", n, dn, exp_done); errors++;
        end
        if (exp_done) begin
          ed = sa[n-10] - sb[n-10];
          last_d = ed;
          checks++;
          if (df[7:0] !== ed || bo !== (sa[n-10] < sb[n-10])) begin
            $display("[TB] FAIL b2b_result[%0d]: got %h/%b expected %h/%b",
                     n, df[7:0], bo, ed, sa[n-10] < sb[n-10]);
            errors++;
          end
        end else begin
          checks++;
          if (df[7:0] !== last_d) begin
            $display("[TB] FAIL b2b_hold[%0d]: got %h expected %h", n, df[7:0], last_d); errors++;
          end
        end
      end
      sa[n] = 8'($urandom);
      sb[n] = 8'($urandom);
      drive(1, 1'b1, {24'd0, sa[n]}, {24'd0, sb[n]});
      @(posedge clk);
      @(negedge clk);
    end
    drive(1, 1'b0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic bz, dn, bo, bres;
    logic [31:0] df, dres;
    int pulses, cyc;
    bit uns, bb;
    drive(1, 1'b1, 32'h10, 32'h20);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sample(1, bz, dn, df, bo);
    checks++;
    if ({bz, dn, bo} !== 3'b000 || df !== 32'd0) begin
      $display("[TB] FAIL midop_reset: got busy=%b done=%b diff=%h borrow=%b expected all zero",
               bz, dn, df, bo);
      errors++;
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      sample(1, bz, dn, df, bo);
      if (dn) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      $display("[TB] FAIL midop_no_done: got %0d pulses expected 0", pulses); errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1, 8, 32'h10, 32'h20, cyc, dres, bres, uns, bb);
    checks++;
    if (cyc != 9 || dres !== 32'hF0 || bres !== 1'b1) begin
      $display("[TB] FAIL midop_restart: got cyc=%0d diff=%h borrow=%b expected 9 f0 1", cyc, dres, bres);
      errors++;
    end
  endtask

  task automatic test_random(input int sel, input int width, input int nops);
    logic [31:0] mask, av, bv, dres;
    logic bres;
    int cyc;
    bit uns, bb;
    mask = (32'd1 << width) - 32'd1;
    for (int i = 0; i < nops; i++) begin
      av = $urandom & mask;
      bv = $urandom & mask;
      case ($urandom_range(0, 9))
        0: bv = av;
        1: begin av = '0; bv = mask; end
        2: begin av = mask; bv = '0; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        drive(sel, 1'b0, $urandom, $urandom);
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end
      run_op(sel, width, av, bv, cyc, dres, bres, uns, bb);
      checks++;
      if (cyc != width + 1) begin
        $display("[TB] FAIL rand_w%0d_latency: got %0d expected %0d", width, cyc, width + 1); errors++;
      end
      checks++;
      if (dres !== ((av - bv) & mask)) begin
        $display("[TB] FAIL rand_w%0d_diff: a=%h b=%h got %h expected %h",
                 width, av, bv, dres, (av - bv) & mask);
        errors++;
      end
      checks++;
      if (bres !== (av < bv)) begin
        $display("[TB] FAIL rand_w%0d_borrow: a=%h b=%h got %b expected %b", width, av, bv, bres, av < bv);
        errors++;
      end
      checks++;
      if (uns) begin
        $display("[TB] FAIL rand_w%0d_stable: diff changed before done, expected held", width); errors++;
      end
      checks++;
      if (bb) begin
        $display("[TB] FAIL rand_w%0d_busy: busy low during run, expected high", width); errors++;
      end
    end
    drive(sel, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_op();
    test_random(0, 1, 400);
    test_random(1, 8, 400);
    test_random(2, 16, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 Port: busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-008 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-009 Port: diff  output  WIDTH  registered result a - b, modulo 2^WIDTH.
REQ-010 Port: borrow_out  output  1  registered final borrow; 1 iff a < b as unsigned values.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture a and b into internal shift registers, clear the internal borrow flop, clear the bit counter and enter RUN.
REQ-013 In RUN, the block SHALL process one bit per cycle, LSB first, using the full-subtractor equations on working bits x, y and borrow-in bi:
- d = x ^ y ^ bi
- bo = (~x & y) | (~(x ^ y) & bi)
REQ-014 In RUN, each cycle SHALL shift d into the MSB of a working result register and load bo into the borrow flop.
REQ-015 After exactly WIDTH RUN cycles, the block SHALL enter DONE and load diff and borrow_out from the working register and the borrow flop.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-017 Latency: for start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH+1, and diff/borrow_out SHALL be valid in that same cycle.
REQ-018 diff and borrow_out SHALL change only on entry to DONE, and SHALL hold their values through IDLE and through the next operation until its own DONE.
REQ-019 start SHALL be ignored in RUN and DONE: no recapture and no effect on the operation in progress.
REQ-020 Back-to-back: start=1 in the first IDLE cycle after DONE SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-021 Changes on a or b after the accept edge SHALL NOT affect the result.
REQ-022 For WIDTH=1, RUN SHALL last exactly one cycle.
REQ-023 The bit counter SHALL be sized to hold the value WIDTH without overflow.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force:
- state = IDLE
- busy = 0, done = 0
- diff = 0, borrow_out = 0
- working registers, borrow flop and counter = 0
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-026 After reset deassertion, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=8'h5A, b=8'h23, start pulse -> done 10 cycles after the accept edge, diff=8'h37, borrow_out=0.
REQ-028 WIDTH=8, a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; a=8'hA5, b=8'hA5 -> diff=8'h00, borrow_out=0.
REQ-029 start=1 held continuously, with a and b changed every cycle during RUN -> one result per 10 cycles, each equal to the operands captured at its own accept edge.
REQ-030 Start with a=8'h10, b=8'h20, then drop rst_n at RUN cycle 4 -> done never pulses, and diff=0, borrow_out=0, busy=0 immediately; the next start with a=8'h10, b=8'h20 -> diff=8'hF0, borrow_out=1.
REQ-031 Random-operand run over at least 1000 operations, WIDTH in {1, 8, 16} -> every result matches (a - b) mod 2^WIDTH and the (a < b) reference model, and diff is stable between done pulses.
